// File: rtl/bullet_pkg.sv
// rtl/bullet_pkg.sv - shared types and screen bounds for the bullet pool
package bullet_pkg;

  typedef enum logic [1:0] {
    LEFT  = 2'b00,
    RIGHT = 2'b01,
    DOWN  = 2'b10,
    UP    = 2'b11
  } dir_t;

  typedef logic [9:0] coord_t;

  typedef enum logic {
    IDLE   = 1'b0,
    FLYING = 1'b1
  } slot_state_t;

  localparam int X_MIN_DEF = 1;
  localparam int X_MAX_DEF = 639;
  localparam int Y_MIN_DEF = 1;
  localparam int Y_MAX_DEF = 479;

endpackage

// File: rtl/bullet_slot.sv
// rtl/bullet_slot.sv - one projectile slot: state, latched heading, position, edge retire
module bullet_slot
  import bullet_pkg::*;
#(
  parameter int STEP  = 8,
  parameter int SIZE  = 4,
  parameter int X_MIN = X_MIN_DEF,
  parameter int X_MAX = X_MAX_DEF,
  parameter int Y_MIN = Y_MIN_DEF,
  parameter int Y_MAX = Y_MAX_DEF
) (
  input  logic       frame_clk,
  input  logic       Reset_n,
  input  logic       launch,
  input  logic [1:0] direction,
  input  logic [9:0] home_x,
  input  logic [9:0] home_y,
  output logic       busy,
  output logic       busy_next,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y
);

  localparam coord_t C_STEP  = coord_t'(STEP);
  localparam coord_t C_SIZE  = coord_t'(SIZE);
  localparam coord_t C_X_MAX = coord_t'(X_MAX);
  localparam coord_t C_Y_MAX = coord_t'(Y_MAX);
  // Low-side limits are folded into constants so the compare never subtracts from the position.
  localparam coord_t C_X_LO  = coord_t'(X_MIN + SIZE);
  localparam coord_t C_Y_LO  = coord_t'(Y_MIN + SIZE);

  slot_state_t state;
  slot_state_t state_next;
  dir_t        dir_q;
  logic        out_of_bounds;

  assign out_of_bounds = (pos_x + C_SIZE >= C_X_MAX) || (pos_x <= C_X_LO) ||
                         (pos_y + C_SIZE >= C_Y_MAX) || (pos_y <= C_Y_LO);

  // State register; reset aborts any flight immediately.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state: launch takes an idle slot airborne, reaching an edge brings it home.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (launch)        state_next = FLYING;
      FLYING:  if (out_of_bounds) state_next = IDLE;
      default:                    state_next = IDLE;
    endcase
  end

  // Outputs: current occupancy, plus next occupancy so the pool can register its count in step.
  always_comb begin
    busy      = (state == FLYING);
    busy_next = (state_next == FLYING);
  end

  // Position datapath: idle slots shadow the player centre, flying slots step along the heading.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pos_x <= '0;
      pos_y <= '0;
      dir_q <= LEFT;
    end else if (state == FLYING && !out_of_bounds) begin
      case (dir_q)
        LEFT:  pos_x <= pos_x - C_STEP;
        RIGHT: pos_x <= pos_x + C_STEP;
        DOWN:  pos_y <= pos_y + C_STEP;
        UP:    pos_y <= pos_y - C_STEP;
      endcase
    end else begin
      pos_x <= home_x;
      pos_y <= home_y;
      if (state == IDLE && launch) dir_q <= dir_t'(direction);
    end
  end

endmodule

// File: rtl/bullet_pool.sv
// rtl/bullet_pool.sv - multi-shot projectile pool with fire edge detect and launch cooldown
module bullet_pool
  import bullet_pkg::*;
#(
  parameter int         NUM_BULLETS = 4,
  parameter logic [7:0] FIRE_KEY    = 8'd88,
  parameter int         STEP        = 8,
  parameter int         SIZE        = 4,
  parameter int         COOLDOWN    = 6,
  parameter int         X_MIN       = X_MIN_DEF,
  parameter int         X_MAX       = X_MAX_DEF,
  parameter int         Y_MIN       = Y_MIN_DEF,
  parameter int         Y_MAX       = Y_MAX_DEF
) (
  input  logic                      frame_clk,
  input  logic                      Reset_n,
  input  logic [1:0]                direction,
  input  logic [7:0]                keycode,
  input  logic [9:0]                BallX,
  input  logic [9:0]                BallY,
  input  logic [9:0]                BallS,
  output logic [10*NUM_BULLETS-1:0] BulletX,
  output logic [10*NUM_BULLETS-1:0] BulletY,
  output logic [9:0]                BulletS,
  output logic [NUM_BULLETS-1:0]    bullet_on,
  output logic                      fire_event,
  output logic [3:0]                active_count
);

  logic                   key_now;
  logic                   key_prev;
  logic                   request;
  logic                   accept;
  logic                   any_idle;
  logic [7:0]             cooldown;
  logic [NUM_BULLETS-1:0] busy;
  logic [NUM_BULLETS-1:0] busy_next;
  logic [NUM_BULLETS-1:0] launch_sel;
  logic [NUM_BULLETS-1:0] launch;
  logic [3:0]             count_next;
  coord_t                 home_x;
  coord_t                 home_y;

  assign home_x  = BallX + BallS;
  assign home_y  = BallY + BallS;
  assign key_now = (keycode == FIRE_KEY);
  assign request = key_now & ~key_prev;
  // Requests that arrive while busy or cooling down are simply dropped.
  assign accept  = Reset_n & request & (cooldown == 8'd0) & any_idle;
  assign launch  = {NUM_BULLETS{accept}} & launch_sel;

  assign fire_event = accept;
  assign bullet_on  = busy;
  assign BulletS    = 10'(SIZE);

  // Key edge register so a held key fires only once.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) key_prev <= 1'b0;
    else          key_prev <= key_now;
  end

  // Cooldown: reload on every accepted launch, otherwise count down to zero.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n)              cooldown <= 8'd0;
    else if (accept)           cooldown <= 8'(COOLDOWN);
    else if (cooldown != 8'd0) cooldown <= cooldown - 8'd1;
  end

  // Priority encoder: pick the lowest-index slot that is idle at the start of this frame.
  always_comb begin
    launch_sel = '0;
    any_idle   = 1'b0;
    for (int i = 0; i < NUM_BULLETS; i++) begin
      if (!busy[i] && !any_idle) begin
        launch_sel[i] = 1'b1;
        any_idle      = 1'b1;
      end
    end
  end

  // Popcount of the slots' next occupancy, so the registered count lines up with bullet_on.
  always_comb begin
    count_next = '0;
    for (int i = 0; i < NUM_BULLETS; i++) count_next = count_next + 4'(busy_next[i]);
  end

  // Registered active-slot count.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) active_count <= 4'd0;
    else          active_count <= count_next;
  end

  for (genvar i = 0; i < NUM_BULLETS; i++) begin : g_slot
    bullet_slot #(
      .STEP  (STEP),
      .SIZE  (SIZE),
      .X_MIN (X_MIN),
      .X_MAX (X_MAX),
      .Y_MIN (Y_MIN),
      .Y_MAX (Y_MAX)
    ) u_slot (
      .frame_clk (frame_clk),
      .Reset_n   (Reset_n),
      .launch    (launch[i]),
      .direction (direction),
      .home_x    (home_x),
      .home_y    (home_y),
      .busy      (busy[i]),
      .busy_next (busy_next[i]),
      .pos_x     (BulletX[10*i +: 10]),
      .pos_y     (BulletY[10*i +: 10])
    );
  end

endmodule
